// File: rtl/cam_lookup_client.sv
// CAM lookup initiator: issues tagged lookups, parks descriptors in an in-order
// pending buffer and joins them with the returned values. Optional watchdog: CAM_CLIENT_TIMEOUT_EN.
module cam_lookup_client #(
  parameter int KEY_SIZE          = 8,
  parameter int VALUE_SIZE        = 32,
  parameter int META_WIDTH        = 16,
  parameter int LOOKUP_USER_WIDTH = 4,
  parameter int MAX_OUTSTANDING   = 8,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [KEY_SIZE-1:0]                s_req_key,
  input  logic [META_WIDTH-1:0]              s_req_meta,
  input  logic                               s_req_valid,
  output logic                               s_req_ready,
  output logic [KEY_SIZE-1:0]                m_lookup_req_index,
  output logic [LOOKUP_USER_WIDTH-1:0]       m_lookup_req_user,
  output logic                               m_lookup_req_valid,
  input  logic                               m_lookup_req_ready,
  input  logic [VALUE_SIZE-1:0]              s_lookup_value_data,
  input  logic [LOOKUP_USER_WIDTH-1:0]       s_lookup_value_user,
  input  logic                               s_lookup_value_valid,
  output logic                               s_lookup_value_ready,
  output logic [KEY_SIZE-1:0]                m_resp_key,
  output logic [META_WIDTH-1:0]              m_resp_meta,
  output logic [VALUE_SIZE-1:0]              m_resp_value,
  output logic                               m_resp_valid,
  input  logic                               m_resp_ready,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_tag_mismatch,
  output logic                               err_timeout
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  typedef struct packed {
    logic [KEY_SIZE-1:0]   key;
    logic [META_WIDTH-1:0] meta;
  } entry_t;

  entry_t                         pending_q [MAX_OUTSTANDING];
  entry_t                         rd_entry;

  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]               count_q, count_d;

  logic                           req_valid_q, req_valid_d;
  logic [KEY_SIZE-1:0]            req_index_q, req_index_d;
  logic [LOOKUP_USER_WIDTH-1:0]   req_user_q, req_user_d;

  logic                           resp_valid_q, resp_valid_d;
  logic [KEY_SIZE-1:0]            resp_key_q, resp_key_d;
  logic [META_WIDTH-1:0]          resp_meta_q, resp_meta_d;
  logic [VALUE_SIZE-1:0]          resp_value_q, resp_value_d;

  logic                           err_tag_q, err_tag_d;

  logic                           lookup_slot_free;
  logic                           req_hs;
  logic                           val_hs;
  logic                           val_accept;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign lookup_slot_free = !req_valid_q || m_lookup_req_ready;
  // rst_n gates readiness so nothing is accepted while reset is held.
  assign s_req_ready          = rst_n && lookup_slot_free && (count_q < FULL_CNT);
  assign s_lookup_value_ready = !resp_valid_q || m_resp_ready;

  assign req_hs     = s_req_valid && s_req_ready;
  assign val_hs     = s_lookup_value_valid && s_lookup_value_ready;
  // A value with nothing pending is a protocol error, not a result.
  assign val_accept = val_hs && (count_q != '0);
  assign rd_entry   = pending_q[rd_ptr_q];

  // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    req_valid_d  = req_valid_q;
    req_index_d  = req_index_q;
    req_user_d   = req_user_q;
    resp_valid_d = resp_valid_q;
    resp_key_d   = resp_key_q;
    resp_meta_d  = resp_meta_q;
    resp_value_d = resp_value_q;
    err_tag_d    = err_tag_q;

    if (req_hs) begin
      req_valid_d = 1'b1;
      req_index_d = s_req_key;
      req_user_d  = LOOKUP_USER_WIDTH'(wr_ptr_q);
      wr_ptr_d    = ptr_next(wr_ptr_q);
    end else if (m_lookup_req_ready) begin
      req_valid_d = 1'b0;
    end

    if (val_accept) begin
      resp_valid_d = 1'b1;
      resp_key_d   = rd_entry.key;
      resp_meta_d  = rd_entry.meta;
      resp_value_d = s_lookup_value_data;
      rd_ptr_d     = ptr_next(rd_ptr_q);
      // Responses are in order, so data still comes from rd_ptr; only the flag records the slip.
      if (s_lookup_value_user != LOOKUP_USER_WIDTH'(rd_ptr_q)) begin
        err_tag_d = 1'b1;
      end
    end else begin
      if (m_resp_ready) begin
        resp_valid_d = 1'b0;
      end
      if (val_hs) begin
        err_tag_d = 1'b1;
      end
    end

    unique case ({req_hs, val_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      req_valid_q  <= 1'b0;
      req_index_q  <= '0;
      req_user_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_key_q   <= '0;
      resp_meta_q  <= '0;
      resp_value_q <= '0;
      err_tag_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      req_valid_q  <= req_valid_d;
      req_index_q  <= req_index_d;
      req_user_q   <= req_user_d;
      resp_valid_q <= resp_valid_d;
      resp_key_q   <= resp_key_d;
      resp_meta_q  <= resp_meta_d;
      resp_value_q <= resp_value_d;
      err_tag_q    <= err_tag_d;
    end
  end

  // NOTE: the pending buffer is not reset; an entry is only read after being written, and the
  // pointers/count that qualify it are reset.
  always_ff @(posedge clk) begin
    if (req_hs) begin
      pending_q[wr_ptr_q] <= '{key: s_req_key, meta: s_req_meta};
    end
  end

  assign m_lookup_req_valid = req_valid_q;
  assign m_lookup_req_index = req_index_q;
  assign m_lookup_req_user  = req_user_q;
  assign m_resp_valid       = resp_valid_q;
  assign m_resp_key         = resp_key_q;
  assign m_resp_meta        = resp_meta_q;
  assign m_resp_value       = resp_value_q;
  assign outstanding        = count_q;
  assign err_tag_mismatch   = err_tag_q;

`ifdef CAM_CLIENT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_timeout_q, err_timeout_d;

  // Counts stalled cycles with work pending; saturates at the limit once the flag is raised.
  always_comb begin
    wd_cnt_d      = wd_cnt_q;
    err_timeout_d = err_timeout_q;
    if ((count_q == '0) || val_hs) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_LIMIT) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
      if (wd_cnt_d == WD_LIMIT) begin
        err_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign err_timeout        = 1'b0;
`endif

endmodule
